// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: a single borrow-chained 1-bit cell computes minuend - subtrahend LSB first.
// Optional build macro SERIAL_SUB_SAT_EN clamps a borrowing result to zero (saturating subtract).
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             outborrow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bin;
  logic             r_outborrow;
  logic             r_busy;
  logic             r_done;

  logic             w_hs1_d;
  logic             w_hs1_b;
  logic             w_hs2_b;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] w_diff_fin;

  // One-bit subtract cell: two cascaded half subtractors, borrows ORed
  assign w_hs1_d = r_m[0] ^ r_s[0];
  assign w_hs1_b = ~r_m[0] & r_s[0];
  assign w_d     = w_hs1_d ^ r_bin;
  assign w_hs2_b = ~w_hs1_d & r_bin;
  assign w_bout  = w_hs1_b | w_hs2_b;

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
  assign w_diff_fin = w_bout ? '0 : w_res_nxt;
`else
  assign w_diff_fin = w_res_nxt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/result shifting, borrow and counter; results publish only on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m         <= '0;
      r_s         <= '0;
      r_res       <= '0;
      r_bin       <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_outborrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= minuend;
            r_s   <= subtrahend;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_m   <= r_m >> 1;
          r_s   <= r_s >> 1;
          r_res <= w_res_nxt;
          r_bin <= w_bout;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff      <= w_diff_fin;
            r_outborrow <= w_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered handshake outputs, derived from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign diff      = r_diff;
  assign outborrow = r_outborrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl at WIDTH=8.
module tb_serial_subtractor_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         outborrow;

  int checks;
  int errors;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .outborrow  (outborrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, wait for done (bounded), return results and latency; ends in the following IDLE cycle
  task automatic do_sub(input logic [W-1:0] m, input logic [W-1:0] s,
                        output logic [W-1:0] d, output logic b, output int lat,
                        output logic [W-1:0] early_diff);
    start = 1'b1;
    minuend = m;
    subtrahend = s;
    step();
    start = 1'b0;
    early_diff = diff;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL do_sub_timeout %0d-%0d: done not seen within %0d cycles", m, s, lat);
    end
    d = diff;
    b = outborrow;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    minuend = '0;
    subtrahend = '0;
    step();
    step();
    checks++;
    if ({busy, done, diff, outborrow} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%0d borrow=%b, required all 0", busy, done, diff, outborrow);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    start = 1'b1;
    minuend = 8'd100;
    subtrahend = 8'd37;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy cycle %0d: got %b, required 1", c, busy);
      end
      checks++;
      if (done !== (c == 9)) begin
        errors++;
        $display("FAIL basic_done cycle %0d: got %b, required %b", c, done, (c == 9));
      end
      if (c < 9) begin
        checks++;
        if (diff !== 8'd0) begin
          errors++;
          $display("FAIL basic_no_partial cycle %0d: diff=%0d, required 0", c, diff);
        end
      end else begin
        checks++;
        if (diff !== 8'd63 || outborrow !== 1'b0) begin
          errors++;
          $display("FAIL basic_result: diff=%0d borrow=%b, required 63 0", diff, outborrow);
        end
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd63) begin
      errors++;
      $display("FAIL basic_idle: busy=%b done=%b diff=%0d, required 0 0 63", busy, done, diff);
    end
  endtask

  task automatic test_borrow();
    logic [W-1:0] d, e;
    logic b;
    int lat;
    logic [W-1:0] exp_d;
`ifdef SERIAL_SUB_SAT_EN
    exp_d = 8'd0;
`else
    exp_d = 8'd252;
`endif
    do_sub(8'd5, 8'd9, d, b, lat, e);
    checks++;
    if (d !== exp_d || b !== 1'b1 || lat != 9) begin
      errors++;
      $display("FAIL borrow_5_9: diff=%0d borrow=%b lat=%0d, required %0d 1 9", d, b, lat, exp_d);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] tm [4];
    logic [W-1:0] ts [4];
    logic [W-1:0] td [4];
    logic         tb [4];
    logic [W-1:0] d, e;
    logic b;
    int lat;
    tm[0] = 8'd0;   ts[0] = 8'd0;   td[0] = 8'd0;   tb[0] = 1'b0;
    tm[1] = 8'd255; ts[1] = 8'd255; td[1] = 8'd0;   tb[1] = 1'b0;
    tm[2] = 8'd0;   ts[2] = 8'd1;   tb[2] = 1'b1;
`ifdef SERIAL_SUB_SAT_EN
    td[2] = 8'd0;
`else
    td[2] = 8'd255;
`endif
    tm[3] = 8'd255; ts[3] = 8'd0;   td[3] = 8'd255; tb[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_sub(tm[i], ts[i], d, b, lat, e);
      checks++;
      if (d !== td[i] || b !== tb[i]) begin
        errors++;
        $display("FAIL boundary_%0d_%0d: diff=%0d borrow=%b, required %0d %b", tm[i], ts[i], d, b, td[i], tb[i]);
      end
    end
  endtask

  task automatic test_hold_start();
    int ndone;
    int cyc_seen [3];
    ndone = 0;
    start = 1'b1;
    minuend = 8'd200;
    subtrahend = 8'd1;
    for (int c = 1; c <= 29; c++) begin
      step();
      if (c == 2) begin
        minuend = 8'd50;
        subtrahend = 8'd7;
      end
      if (c == 6) begin
        minuend = 8'd200;
        subtrahend = 8'd1;
      end
      if (done) begin
        if (ndone < 3) cyc_seen[ndone] = c;
        ndone++;
        checks++;
        if (diff !== 8'd199 || outborrow !== 1'b0) begin
          errors++;
          $display("FAIL hold_result cycle %0d: diff=%0d borrow=%b, required 199 0", c, diff, outborrow);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL hold_count: %0d done pulses, required 3", ndone);
    end else begin
      checks++;
      if (cyc_seen[0] != 9 || cyc_seen[1] != 19 || cyc_seen[2] != 29) begin
        errors++;
        $display("FAIL hold_spacing: done at %0d %0d %0d, required 9 19 29", cyc_seen[0], cyc_seen[1], cyc_seen[2]);
      end
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_drain: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d, e;
    logic b;
    int lat;
    int seen;
    start = 1'b1;
    minuend = 8'd50;
    subtrahend = 8'd20;
    step();
    start = 1'b0;
    seen = 0;
    for (int c = 1; c < 4; c++) begin
      if (done) seen++;
      step();
    end
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || outborrow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b diff=%0d borrow=%b, required all 0", busy, done, diff, outborrow);
    end
    for (int c = 0; c < 12; c++) begin
      if (done || busy) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midreset_quiet: %0d cycles with busy/done, required 0", seen);
    end
    do_sub(8'd50, 8'd20, d, b, lat, e);
    checks++;
    if (d !== 8'd30 || b !== 1'b0 || lat != 9) begin
      errors++;
      $display("FAIL midreset_fresh: diff=%0d borrow=%b lat=%0d, required 30 0 9", d, b, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d, e;
    logic b;
    int lat;
    logic [W-1:0] exp_d;
`ifdef SERIAL_SUB_SAT_EN
    exp_d = 8'd0;
`else
    exp_d = 8'd249;
`endif
    do_sub(8'd10, 8'd3, d, b, lat, e);
    checks++;
    if (d !== 8'd7 || b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: diff=%0d borrow=%b, required 7 0", d, b);
    end
    checks++;
    if (busy !== 1'b0 || diff !== 8'd7) begin
      errors++;
      $display("FAIL b2b_idle_hold: busy=%b diff=%0d, required 0 7", busy, diff);
    end
    do_sub(8'd3, 8'd10, d, b, lat, e);
    checks++;
    if (e !== 8'd7) begin
      errors++;
      $display("FAIL b2b_hold_during_shift: diff=%0d, required 7", e);
    end
    checks++;
    if (d !== exp_d || b !== 1'b1 || lat != 9) begin
      errors++;
      $display("FAIL b2b_second: diff=%0d borrow=%b lat=%0d, required %0d 1 9", d, b, lat, exp_d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    minuend = '0;
    subtrahend = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_boundary();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
